regfile_param: RTL and testbench
================================

# regfile_param

Parametrised multi-port register file for the processor datapath. It provides two combinational read ports and a core write port with optional same-cycle write-to-read forwarding; register 0 is hardwired to zero. A contiguous window of registers is exported as a flat tap bus for I/O logic. A second, handshaked write port lets I/O logic write into that window; it has a one-entry commit buffer, collision retry, and a starvation drop.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2^ADDR_W registers.
- BYPASS, 1, 1 = forward same-cycle writes to read ports; 0 = reads return stored value only.
- TAP_BASE, 20, index of the first exported register; must be ≥1.
- TAP_CNT, 10, number of exported registers; TAP_BASE+TAP_CNT ≤ 2^ADDR_W.
- RETRY_MAX, 4, consecutive collision retries before a buffered ext write is dropped; ≥1.

Ports (OFF_W = clog2(TAP_CNT)):
- clock  in  1  sole clock; all state updates on rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- ctrl_writeEnable  in  1  core write strobe.
- ctrl_writeReg  in  ADDR_W  core write address.
- data_writeReg  in  DATA_W  core write data.
- ctrl_readRegA  in  ADDR_W  read port A address.
- ctrl_readRegB  in  ADDR_W  read port B address.
- data_readRegA  out  DATA_W  read port A data (combinational).
- data_readRegB  out  DATA_W  read port B data (combinational).
- ext_valid  in  1  ext write request.
- ext_ready  out  1  commit buffer empty; request accepted when ext_valid && ext_ready.
- ext_off  in  OFF_W  offset into tap window.
- ext_data  in  DATA_W  ext write data.
- ext_drop  out  1  one-cycle pulse: buffered or accepted ext write discarded.
- tap_data  out  TAP_CNT*DATA_W  registers TAP_BASE..TAP_BASE+TAP_CNT-1; slice k = reg TAP_BASE+k.

## Operation
- Core write: on each edge with ctrl_writeEnable=1 and ctrl_writeReg≠0, reg[ctrl_writeReg] ← data_writeReg. Writes to reg 0 are ignored; reg 0 always reads 0.
- Reads: data_readRegX = reg[ctrl_readRegX].
  - With BYPASS=1, a core write to the same nonzero address in the same cycle forwards data_writeReg instead.
  - With BYPASS=1, a committing ext write to the same address (and no core write to it) forwards the ext buffer data.
  - Reading address 0 always returns 0, regardless of bypass.
- Ext buffer: holds buf_valid, buf_reg (absolute index), buf_data, and a retry counter.
  - Accept: when ext_valid && ext_ready at an edge, load buf_reg = TAP_BASE+ext_off and buf_data = ext_data, set buf_valid, clear the retry counter.
  - Out-of-window offset: if ext_off ≥ TAP_CNT, nothing is buffered and ext_drop pulses the next cycle.
  - ext_ready = !buf_valid, so the buffer holds at most one entry and accept/commit never occur in the same cycle.
- Commit: each cycle with buf_valid=1.
  - No collision (not ctrl_writeEnable, or ctrl_writeReg≠buf_reg): reg[buf_reg] ← buf_data at the edge and buf_valid clears.
  - Collision (core writes buf_reg): the core write wins, the buffer holds, and the retry counter increments.
  - Starvation: on the collision that brings the count to RETRY_MAX, the buffer clears and ext_drop pulses the following cycle.
- The core and ext ports write different registers in the same edge (dual write).
- tap_data reflects stored values only, never bypass data.

## Timing
- Reset (edge with ctrl_reset=1):
  - all registers ← 0; buf_valid ← 0; retry counter ← 0; ext_drop ← 0.
  - Core and ext writes in the reset cycle are ignored; a buffered ext write is discarded without an ext_drop pulse.
  - ext_ready = 1 from the first cycle after reset.
- Core write latency: visible at the read ports combinationally (BYPASS=1) or the cycle after the edge (BYPASS=0). Visible on tap_data the cycle after the edge.
- Ext write latency: accepted at edge N, committed at edge N+1 if uncontested. Visible on tap_data from cycle N+2; ext_ready is low during cycle N+1 only.
- ext_drop is registered, high for exactly one cycle.
- Simultaneous core and ext writes to different registers: both take effect at the same edge.

## Test plan
- Reset, then read A=0, B=31 → both 0. Core write reg5=0xDEADBEEF; same cycle read A=5 → 0xDEADBEEF (BYPASS=1); next cycle read → 0xDEADBEEF. Write reg0=0x1234 → read 0 returns 0.
- BYPASS=0 build: write reg7=0xA5A5A5A5 with read A=7 in the same cycle → old value 0; next cycle → 0xA5A5A5A5.
- Ext write off=3, data=0x55 with no core traffic → ext_ready low one cycle; tap slice 3 (reg23) = 0x55 two cycles after accept. Same edge as the commit, core writes reg6=0x66 → both registers updated.
- Ext buffered for reg22 while the core writes reg22 three consecutive cycles (RETRY_MAX=4), then idles → reg22 = ext data after the 4th edge, no ext_drop.
- Core writes reg22 for 4 consecutive cycles while ext is buffered → ext_drop pulses once, reg22 = last core value, ext_ready returns high. Ext off=12 (≥TAP_CNT) → ext_drop pulse, no register changes.
- Assert ctrl_reset one cycle while ext is buffered and core writes are active → all taps 0, no ext_drop, ext_ready=1 the next cycle.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, a core write port with
// optional forwarding, an exported tap window, and a handshaked ext write port into it.
module regfile_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BYPASS    = 1,
    parameter int TAP_BASE  = 20,
    parameter int TAP_CNT   = 10,
    parameter int RETRY_MAX = 4,
    localparam int OFF_W    = (TAP_CNT > 1) ? $clog2(TAP_CNT) : 1
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    input  logic                      ctrl_writeEnable,
    input  logic [ADDR_W-1:0]         ctrl_writeReg,
    input  logic [DATA_W-1:0]         data_writeReg,
    input  logic [ADDR_W-1:0]         ctrl_readRegA,
    input  logic [ADDR_W-1:0]         ctrl_readRegB,
    output logic [DATA_W-1:0]         data_readRegA,
    output logic [DATA_W-1:0]         data_readRegB,
    input  logic                      ext_valid,
    output logic                      ext_ready,
    input  logic [OFF_W-1:0]          ext_off,
    input  logic [DATA_W-1:0]         ext_data,
    output logic                      ext_drop,
    output logic [TAP_CNT*DATA_W-1:0] tap_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int RW    = $clog2(RETRY_MAX + 1);
    localparam logic [OFF_W:0]    OFF_LIM   = (OFF_W + 1)'(TAP_CNT);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(TAP_BASE);
    localparam logic [RW-1:0]     RETRY_LIM = RW'(RETRY_MAX);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_reg;
    logic [DATA_W-1:0] r_buf_data;
    logic [RW-1:0]     r_retry;
    logic              r_drop;

    logic              w_core_we;
    logic              w_accept;
    logic              w_in_win;
    logic              w_collide;
    logic              w_commit;
    logic              w_starve;
    logic [RW-1:0]     w_retry_nxt;
    logic [ADDR_W-1:0] w_ext_reg;

    assign w_core_we   = ctrl_writeEnable && (ctrl_writeReg != {ADDR_W{1'b0}});
    assign w_accept    = ext_valid && !r_buf_valid;
    assign w_in_win    = ({1'b0, ext_off} < OFF_LIM);
    assign w_ext_reg   = BASE_A + ADDR_W'(ext_off);
    // buf_reg is never 0 (TAP_BASE >= 1), so ctrl_writeEnable alone identifies a core write to it
    assign w_collide   = r_buf_valid && ctrl_writeEnable && (ctrl_writeReg == r_buf_reg);
    assign w_commit    = r_buf_valid && !w_collide;
    assign w_retry_nxt = r_retry + RW'(1);
    assign w_starve    = w_collide && (w_retry_nxt == RETRY_LIM);

    assign ext_ready = !r_buf_valid;
    assign ext_drop  = r_drop;

    // Register array: core and ext commits always target different registers.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w_core_we) begin
                r_regs[ctrl_writeReg] <= data_writeReg;
            end
            if (w_commit) begin
                r_regs[r_buf_reg] <= r_buf_data;
            end
        end
    end

    // Ext commit buffer, retry counter and drop pulse.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_buf_valid <= 1'b0;
            r_buf_reg   <= {ADDR_W{1'b0}};
            r_buf_data  <= {DATA_W{1'b0}};
            r_retry     <= {RW{1'b0}};
            r_drop      <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_accept) begin
                if (w_in_win) begin
                    r_buf_valid <= 1'b1;
                    r_buf_reg   <= w_ext_reg;
                    r_buf_data  <= ext_data;
                    r_retry     <= {RW{1'b0}};
                end else begin
                    r_drop <= 1'b1;
                end
            end else if (w_collide) begin
                if (w_starve) begin
                    r_buf_valid <= 1'b0;
                    r_retry     <= {RW{1'b0}};
                    r_drop      <= 1'b1;
                end else begin
                    r_retry <= w_retry_nxt;
                end
            end else if (w_commit) begin
                r_buf_valid <= 1'b0;
                r_retry     <= {RW{1'b0}};
            end
        end
    end

    // Read ports: core write forwarding takes priority over a committing ext write.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_rd;
        assign w_addr = (p == 0) ? ctrl_readRegA : ctrl_readRegB;

        always_comb begin
            w_rd = r_regs[w_addr];
            if (w_addr == {ADDR_W{1'b0}}) begin
                w_rd = {DATA_W{1'b0}};
            end else if ((BYPASS != 0) && w_core_we && (ctrl_writeReg == w_addr)) begin
                w_rd = data_writeReg;
            end else if ((BYPASS != 0) && w_commit && (r_buf_reg == w_addr)) begin
                w_rd = r_buf_data;
            end else begin
                w_rd = r_regs[w_addr];
            end
        end
    end

    assign data_readRegA = g_rd[0].w_rd;
    assign data_readRegB = g_rd[1].w_rd;

    for (genvar k = 0; k < TAP_CNT; k++) begin : g_tap
        assign tap_data[k*DATA_W +: DATA_W] = r_regs[TAP_BASE + k];
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a BYPASS=1 and a BYPASS=0 instance share stimulus;
// expectations are queued at stimulus time and popped against DUT outputs.
module tb_regfile_param;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic        ext_valid;
    logic [3:0]  ext_off;
    logic [31:0] ext_data;

    logic [31:0]  a0, b0, a1, b1;
    logic         rdy0, drop0, rdy1, drop1;
    logic [319:0] tap0, tap1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_tap [10];

    always #5 clock = ~clock;

    regfile_param #(.BYPASS(1)) dut0 (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(a0), .data_readRegB(b0),
        .ext_valid(ext_valid), .ext_ready(rdy0), .ext_off(ext_off), .ext_data(ext_data),
        .ext_drop(drop0), .tap_data(tap0)
    );

    regfile_param #(.BYPASS(0)) dut1 (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(a1), .data_readRegB(b1),
        .ext_valid(ext_valid), .ext_ready(rdy1), .ext_off(ext_off), .ext_data(ext_data),
        .ext_drop(drop1), .tap_data(tap1)
    );

    function automatic logic [31:0] tap(input int k);
        return tap0[k*32 +: 32];
    endfunction

    task automatic expect_q(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ctrl_reset       = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        ext_valid        = 1'b0;
        ext_off          = 4'd0;
        ext_data         = 32'd0;
    endtask

    task automatic check_taps(input string tag);
        for (int k = 0; k < 10; k++) expect_q($sformatf("%s_tap%0d", tag, k), exp_tap[k]);
        for (int k = 0; k < 10; k++) observe(tap(k));
    endtask

    initial begin
        idle();
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd31;
        for (int k = 0; k < 10; k++) exp_tap[k] = 32'd0;

        // reset
        ctrl_reset = 1'b1;
        cyc(); cyc();
        ctrl_reset = 1'b0;
        expect_q("rst_rdA", 32'd0); expect_q("rst_rdB", 32'd0);
        expect_q("rst_ready", 32'd1); expect_q("rst_drop", 32'd0);
        #3;
        observe(a0); observe(b0); observe({31'd0, rdy0}); observe({31'd0, drop0});
        check_taps("rst");

        // core write reg5 with same-cycle read
        cyc();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
        ctrl_readRegA = 5'd5;
        expect_q("byp_rd5", 32'hDEADBEEF); expect_q("nobyp_rd5_old", 32'd0);
        #3; observe(a0); observe(a1);
        cyc();
        idle();
        expect_q("byp_rd5_next", 32'hDEADBEEF); expect_q("nobyp_rd5_next", 32'hDEADBEEF);
        #3; observe(a0); observe(a1);

        // write reg0 ignored
        cyc();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h1234;
        ctrl_readRegA = 5'd0;
        expect_q("rd0_same", 32'd0);
        #3; observe(a0);
        cyc();
        idle();
        expect_q("rd0_next_byp", 32'd0); expect_q("rd0_next_nobyp", 32'd0);
        #3; observe(a0); observe(a1);

        // reg7 write: old value on BYPASS=0 build
        cyc();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'hA5A5A5A5;
        ctrl_readRegA = 5'd7;
        expect_q("nobyp_rd7_old", 32'd0); expect_q("byp_rd7", 32'hA5A5A5A5);
        #3; observe(a1); observe(a0);
        cyc();
        idle();
        expect_q("nobyp_rd7_next", 32'hA5A5A5A5);
        #3; observe(a1);

        // ext write off=3, core writes reg6 at the commit edge
        cyc();
        ext_valid = 1'b1; ext_off = 4'd3; ext_data = 32'h55;
        expect_q("ext_ready_pre", 32'd1);
        #3; observe({31'd0, rdy0});
        cyc();
        idle();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd6; data_writeReg = 32'h66;
        ctrl_readRegA = 5'd23; ctrl_readRegB = 5'd6;
        expect_q("ext_ready_low", 32'd0); expect_q("tap3_pre", 32'd0);
        expect_q("byp_ext_fwd23", 32'h55); expect_q("nobyp_rd23_old", 32'd0);
        expect_q("byp_rd6", 32'h66);
        #3; observe({31'd0, rdy0}); observe(tap(3)); observe(a0); observe(a1); observe(b0);
        cyc();
        idle();
        exp_tap[3] = 32'h55;
        expect_q("ext_ready_back", 32'd1); expect_q("dual_rd6", 32'h66);
        expect_q("ext_drop_none", 32'd0);
        #3; observe({31'd0, rdy0}); observe(b1); observe({31'd0, drop0});
        check_taps("ext3");

        // three collisions then commit
        cyc();
        ext_valid = 1'b1; ext_off = 4'd2; ext_data = 32'hE2E2;
        ctrl_readRegA = 5'd22;
        for (int i = 0; i < 3; i++) begin
            cyc();
            idle();
            ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd22; data_writeReg = 32'h100 + i;
            expect_q($sformatf("retry_ready%0d", i), 32'd0);
            expect_q($sformatf("retry_fwd%0d", i), 32'h100 + i);
            #3; observe({31'd0, rdy0}); observe(a0);
        end
        cyc();
        idle();
        expect_q("retry3_drop", 32'd0); expect_q("retry3_fwd_ext", 32'hE2E2);
        expect_q("retry3_nobyp", 32'h102);
        #3; observe({31'd0, drop0}); observe(a0); observe(a1);
        cyc();
        exp_tap[2] = 32'hE2E2;
        expect_q("retry_commit_rd", 32'hE2E2); expect_q("retry_commit_ready", 32'd1);
        expect_q("retry_commit_drop", 32'd0);
        #3; observe(a1); observe({31'd0, rdy0}); observe({31'd0, drop0});
        check_taps("retry");

        // starvation: four collisions
        cyc();
        ext_valid = 1'b1; ext_off = 4'd2; ext_data = 32'hBAD;
        for (int i = 0; i < 4; i++) begin
            cyc();
            idle();
            ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd22; data_writeReg = 32'h200 + i;
            expect_q($sformatf("starve_drop_low%0d", i), 32'd0);
            #3; observe({31'd0, drop0});
        end
        cyc();
        idle();
        exp_tap[2] = 32'h203;
        expect_q("starve_drop", 32'd1); expect_q("starve_ready", 32'd1);
        expect_q("starve_rd22", 32'h203);
        #3; observe({31'd0, drop0}); observe({31'd0, rdy0}); observe(a1);
        cyc();
        expect_q("starve_drop_once", 32'd0);
        #3; observe({31'd0, drop0});
        check_taps("starve");

        // out-of-window offset
        cyc();
        ext_valid = 1'b1; ext_off = 4'd12; ext_data = 32'hFFFF;
        cyc();
        idle();
        expect_q("oow_drop", 32'd1); expect_q("oow_ready", 32'd1);
        #3; observe({31'd0, drop0}); observe({31'd0, rdy0});
        check_taps("oow");
        cyc();
        expect_q("oow_drop_once", 32'd0);
        #3; observe({31'd0, drop0});

        // reset while buffered with core traffic
        cyc();
        ext_valid = 1'b1; ext_off = 4'd5; ext_data = 32'h77;
        cyc();
        idle();
        ctrl_reset = 1'b1;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd25; data_writeReg = 32'h99;
        cyc();
        idle();
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd7;
        for (int k = 0; k < 10; k++) exp_tap[k] = 32'd0;
        expect_q("rst2_drop", 32'd0); expect_q("rst2_ready", 32'd1);
        expect_q("rst2_rd5", 32'd0); expect_q("rst2_rd7", 32'd0);
        #3; observe({31'd0, drop0}); observe({31'd0, rdy0}); observe(a1); observe(b1);
        check_taps("rst2");
        cyc();
        expect_q("rst2_drop_after", 32'd0); expect_q("rst2_tap5_after", 32'd0);
        #3; observe({31'd0, drop0}); observe(tap(5));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
